instr_fetch: RTL
================

# instr_fetch

Instruction fetch stage that sits directly downstream of the program counter. It latches the current PC value and issues a single-outstanding read to instruction memory over a req/ack handshake. It then holds the returned word in an instruction register and presents it to decode over a valid/ready handshake. It also drives the PC increment strobe and discards in-flight fetches on a jump flush.

## Interface
Parameters:
- `DATA_W`, default 16: instruction width.
- `ADDR_W`, default 16: address width; matches the PC width.
- `MAX_WAIT`, default 255: maximum number of cycles to wait for `IF_mem_ack` before the timeout error.

Ports:
- `IF_clk`, in, 1: clock, rising edge.
- `IF_rst_n`, in, 1: reset.
  - One clock; reset is asynchronous and active-low.
- `IF_pc`, in, `ADDR_W`: current PC value from the PC stage.
- `IF_pc_inc`, out, 1: increment strobe to the PC stage; combinational.
- `IF_flush`, in, 1: single-cycle pulse, asserted in the same cycle as the PC jump.
- `IF_mem_addr`, out, `ADDR_W`: memory read address.
- `IF_mem_req`, out, 1: memory read request.
- `IF_mem_ack`, in, 1: memory acknowledge; `IF_mem_data` is valid in the same cycle.
- `IF_mem_data`, in, `DATA_W`: memory read data.
- `IF_instr`, out, `DATA_W`: instruction register.
- `IF_instr_pc`, out, `ADDR_W`: address the instruction in `IF_instr` was fetched from.
- `IF_valid`, out, 1: `IF_instr` is valid for decode.
- `IF_ready`, in, 1: decode accepts the instruction.
- `IF_err`, out, 1: sticky memory-timeout error.

## Operation
States: `IDLE`, `FETCH`, `HOLD`, `DISCARD`, `ERROR`.

- **IDLE**: the state entered on reset.
  - Unconditionally goes to `FETCH` next cycle.
  - Latches `IF_pc` into the address register on that edge.
- **FETCH**: `IF_mem_req`=1 and `IF_mem_addr` = latched address, held stable until ack.
  - On ack with no flush: capture `IF_mem_data` into `IF_instr` and the address into `IF_instr_pc`, set `IF_valid`, go to `HOLD`.
  - On ack, `IF_pc_inc`=1 in that same cycle, so the PC advances on the same edge.
- **HOLD**: `IF_valid`=1 and `IF_mem_req`=0.
  - `IF_ready`=1: clear valid, latch `IF_pc`, go to `FETCH`.
  - `IF_ready`=0: hold `IF_instr`, `IF_instr_pc` and `IF_valid` unchanged.
- **DISCARD**: the request stays asserted at the old address until ack, because the handshake cannot be aborted.
  - On ack: data dropped, `IF_pc_inc`=0, latch `IF_pc` (the jump target), go to `FETCH`.
- **ERROR**: `IF_err`=1, `IF_mem_req`=0, `IF_valid`=0.
  - Left only by reset.

Flush rules; `IF_flush` has priority over `IF_ready` and `IF_mem_ack`:
- In `HOLD`: clear valid, latch `IF_pc`, go to `FETCH`.
- In `FETCH` with no ack: go to `DISCARD`.
- In `FETCH` with ack in the same cycle: drop the data, `IF_pc_inc`=0, latch `IF_pc`, go to `FETCH`.
- In `IDLE`: no effect beyond the normal transition.
- In `DISCARD`: no additional effect.

Timeout:
- A wait counter, `$clog2(MAX_WAIT+1)` bits, clears on entry to `FETCH` or `DISCARD` and increments each cycle without ack.
- If the counter equals `MAX_WAIT` and there is no ack, go to `ERROR`.

`IF_pc_inc` = (state==`FETCH`) & `IF_mem_ack` & ~`IF_flush`. It is never asserted in any other state.

## Timing
- Reset values: state `IDLE`, `IF_instr`=0, `IF_instr_pc`=0, `IF_valid`=0, `IF_err`=0, address register 0, wait counter 0.
  - Reset values of the combinational outputs: `IF_mem_req`=0, `IF_pc_inc`=0.
- Latency:
  - A zero-wait memory (ack in the first `FETCH` cycle) gives `IF_valid` one cycle after `FETCH` entry.
  - Steady-state throughput with `IF_ready` tied high is one instruction per 2 cycles (`FETCH`, `HOLD`).
- `IF_mem_req` and `IF_mem_addr` are registered-state-derived and glitch-free. They remain constant from request assertion through the ack cycle.
- `IF_instr` and `IF_instr_pc` change only on the edge that enters `HOLD`.
- Reset asserted mid-fetch: outputs drop asynchronously. The ack for the abandoned request is the memory's responsibility; it must be ignored after reset.
- Address wrap: the PC value 16'hFFFF is fetched normally. The block performs no address arithmetic.

## Structure
- Shared package `cpu_pkg`:
  - State enumeration `if_state_t`.
  - Widths `DATA_W` and `ADDR_W`, shared with the PC.
  - Constant `IF_MAX_WAIT`.
- A single module; no sub-module is required.
  - The wait counter may be factored as `if_wait_ctr` (clear/enable/terminal-count) when it is reused by the data-memory stage.

## Test plan
- Reset, then `IF_pc`=0x0010 with a zero-wait memory returning 0xA5A5:
  - `IF_mem_addr`=0x0010.
  - `IF_pc_inc` pulses in the ack cycle.
  - Next cycle: `IF_valid`=1, `IF_instr`=0xA5A5, `IF_instr_pc`=0x0010.
- `IF_ready`=0 for 5 cycles in `HOLD`: `IF_instr` stays stable, `IF_mem_req`=0, `IF_pc_inc`=0. Raising `IF_ready` starts a fetch at the incremented PC, 0x0011.
- Memory ack delayed by 3 cycles: `IF_mem_req` and `IF_mem_addr` are stable for 4 cycles, with exactly one `IF_pc_inc` pulse.
- Flush, jump target 0x0200:
  - Flush in `FETCH` two cycles before ack: the ack data is discarded with no `IF_pc_inc` and no `IF_valid`. The next request goes to 0x0200.
  - Flush in `HOLD`: valid clears, and the next fetch is from 0x0200.
- Flush in the same cycle as ack: no `IF_pc_inc`, no `IF_valid`, and a new request to 0x0200 the following cycle.
- Memory never acks with `MAX_WAIT`=4:
  - `IF_err` rises 5 cycles after `FETCH` entry.
  - `IF_mem_req` drops.
  - `IF_err` stays high until `IF_rst_n` is asserted mid-test, which returns the block to `IDLE` immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths, fetch constants and fetch state encoding
package cpu_pkg;

  localparam int DATA_W      = 16;
  localparam int ADDR_W      = 16;
  localparam int IF_MAX_WAIT = 255;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    HOLD    = 3'd2,
    DISCARD = 3'd3,
    ERROR   = 3'd4
  } if_state_t;

endpackage

// File: rtl/if_wait_ctr.sv
// rtl/if_wait_ctr.sv - memory wait counter with clear, enable and terminal count
module if_wait_ctr #(
  parameter int MAX_WAIT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == CNT_W'(MAX_WAIT));

  // Saturates at the terminal count so a caller that ignores tc never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-outstanding instruction fetch stage with flush and timeout
module instr_fetch #(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int ADDR_W   = cpu_pkg::ADDR_W,
  parameter int MAX_WAIT = cpu_pkg::IF_MAX_WAIT
) (
  input  logic              IF_clk,
  input  logic              IF_rst_n,
  input  logic [ADDR_W-1:0] IF_pc,
  output logic              IF_pc_inc,
  input  logic              IF_flush,
  output logic [ADDR_W-1:0] IF_mem_addr,
  output logic              IF_mem_req,
  input  logic              IF_mem_ack,
  input  logic [DATA_W-1:0] IF_mem_data,
  output logic [DATA_W-1:0] IF_instr,
  output logic [ADDR_W-1:0] IF_instr_pc,
  output logic              IF_valid,
  input  logic              IF_ready,
  output logic              IF_err
);

  import cpu_pkg::*;

  if_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              pc_inc;
  logic              wait_clr;
  logic              wait_en;
  logic              wait_tc;

  assign wait_en = ((state_q == FETCH) || (state_q == DISCARD)) && !IF_mem_ack;

  if_wait_ctr #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_ctr (
    .clk_i (IF_clk),
    .rst_ni(IF_rst_n),
    .clr_i (wait_clr),
    .en_i  (wait_en),
    .tc_o  (wait_tc)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    wait_clr   = 1'b0;
    pc_inc     = 1'b0;
    case (state_q)
      IDLE: begin
        state_d  = FETCH;
        addr_d   = IF_pc;
        wait_clr = 1'b1;
      end
      FETCH: begin
        if (IF_mem_ack) begin
          wait_clr = 1'b1;
          if (IF_flush) begin
            // Data belongs to the pre-jump stream: drop it and refetch at the target.
            addr_d = IF_pc;
          end else begin
            pc_inc     = 1'b1;
            instr_d    = IF_mem_data;
            instr_pc_d = addr_q;
            state_d    = HOLD;
          end
        end else if (wait_tc) begin
          state_d = ERROR;
        end else if (IF_flush) begin
          state_d  = DISCARD;
          wait_clr = 1'b1;
        end
      end
      HOLD: begin
        if (IF_flush || IF_ready) begin
          addr_d   = IF_pc;
          state_d  = FETCH;
          wait_clr = 1'b1;
        end
      end
      DISCARD: begin
        if (IF_mem_ack) begin
          addr_d   = IF_pc;
          state_d  = FETCH;
          wait_clr = 1'b1;
        end else if (wait_tc) begin
          state_d = ERROR;
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge IF_clk or negedge IF_rst_n) begin
    if (!IF_rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign IF_pc_inc   = pc_inc;
  assign IF_mem_req  = (state_q == FETCH) || (state_q == DISCARD);
  assign IF_mem_addr = addr_q;
  assign IF_instr    = instr_q;
  assign IF_instr_pc = instr_pc_q;
  assign IF_valid    = (state_q == HOLD);
  assign IF_err      = (state_q == ERROR);

endmodule
